// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the tone generator stages.
package audio_pkg;

  localparam int AUDIO_W     = 32;
  localparam int VOL_W       = 8;
  localparam int SAMPLE_RATE = 48000;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DECAY
  } env_state_t;

endpackage : audio_pkg

// File: rtl/sample_scaler.sv
// Combinational signed sample x unsigned volume, floored arithmetic shift by VOL_W.
module sample_scaler
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_W,
  parameter int LEVEL_W  = VOL_W
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [LEVEL_W-1:0]  level,
  output logic signed [SAMPLE_W-1:0] scaled
);

  logic signed [SAMPLE_W+LEVEL_W:0] product;
  logic                             unused_bits;

  // Zero-extending the level keeps it non-negative in the signed multiply.
  assign product     = sample * $signed({1'b0, level});
  assign scaled      = product[SAMPLE_W+LEVEL_W-1:LEVEL_W];
  assign unused_bits = ^{product[SAMPLE_W+LEVEL_W], product[LEVEL_W-1:0]};

endmodule : sample_scaler

// File: rtl/note_fade_writer.sv
// Hold/decay volume envelope applied to tone samples, paced into the codec FIFO.
//
// state | meaning
// IDLE  | no note; volume 0, zero samples still written
// HOLD  | volume at VOL_MAX, counting accepted writes
// DECAY | volume stepping down every SAMPLES_PER_STEP writes
module note_fade_writer
  import audio_pkg::*;
#(
  parameter int VOL_MAX          = 255,
  parameter int HOLD_SAMPLES     = 4800,
  parameter int SAMPLES_PER_STEP = 192,
  parameter int DECAY_STEP       = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      note_on,
  input  logic                      note_off,
  input  logic signed [AUDIO_W-1:0] sample_in,
  input  logic                      audio_out_allowed,
  output logic signed [AUDIO_W-1:0] left_channel_audio_out,
  output logic signed [AUDIO_W-1:0] right_channel_audio_out,
  output logic                      write_audio_out,
  output logic        [VOL_W-1:0]   volume,
  output logic                      busy
);

  localparam int HC_W = $clog2(HOLD_SAMPLES + 1);
  localparam int SC_W = $clog2(SAMPLES_PER_STEP + 1);

  env_state_t               state, state_nxt;
  logic [VOL_W-1:0]         vol_nxt, vol_dec;
  logic [HC_W-1:0]          hold_cnt, hold_nxt;
  logic [SC_W-1:0]          step_cnt, step_nxt;
  logic signed [AUDIO_W-1:0] scaled;
  logic                     launch;

  // A new strobe may only follow a cycle without one.
  assign launch = audio_out_allowed && !write_audio_out;

  sample_scaler #(
    .SAMPLE_W (AUDIO_W),
    .LEVEL_W  (VOL_W)
  ) u_scaler (
    .sample (sample_in),
    .level  (volume),
    .scaled (scaled)
  );

  always_comb begin
    vol_dec   = (int'(volume) <= DECAY_STEP) ? '0 : volume - VOL_W'(DECAY_STEP);
    state_nxt = state;
    vol_nxt   = volume;
    hold_nxt  = hold_cnt;
    step_nxt  = step_cnt;
    if (note_on) begin
      state_nxt = HOLD;
      vol_nxt   = VOL_W'(VOL_MAX);
      hold_nxt  = '0;
      step_nxt  = '0;
    end else begin
      case (state)
        IDLE: vol_nxt = '0;
        HOLD: begin
          if (note_off) begin
            state_nxt = DECAY;
            step_nxt  = '0;
          end else if (write_audio_out) begin
            if (hold_cnt == HC_W'(HOLD_SAMPLES - 1)) begin
              state_nxt = DECAY;
              step_nxt  = '0;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end
        end
        DECAY: begin
          if (write_audio_out) begin
            if (step_cnt == SC_W'(SAMPLES_PER_STEP - 1)) begin
              vol_nxt  = vol_dec;
              step_nxt = '0;
              if (vol_dec == '0) state_nxt = IDLE;
            end else begin
              step_nxt = step_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      volume   <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      volume   <= vol_nxt;
      hold_cnt <= hold_nxt;
      step_cnt <= step_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      write_audio_out <= launch;
      if (launch) begin
        left_channel_audio_out  <= scaled;
        right_channel_audio_out <= scaled;
      end
    end
  end

endmodule : note_fade_writer

// File: tb/tb_note_fade_writer.sv
// Randomized and directed checks of note_fade_writer against an envelope reference model.
module tb_note_fade_writer;

  localparam int HOLD = 8;
  localparam int SPS  = 4;
  localparam int VMAX = 255;

  logic               clk = 1'b0;
  logic               rst, note_on, note_off, allowed;
  logic signed [31:0] sample;
  logic        [31:0] left0, right0, left1, right1;
  logic               wr0, wr1, busy0, busy1;
  logic        [7:0]  vol0, vol1;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 hold, 2 decay
  int     m_phase[2];
  int     m_hold[2];
  int     m_dw[2];
  int     m_vol[2];
  longint m_left[2];
  bit     m_wr;

  always #5 clk = ~clk;

  note_fade_writer #(.VOL_MAX(VMAX), .HOLD_SAMPLES(HOLD), .SAMPLES_PER_STEP(SPS), .DECAY_STEP(1)) dut (
    .CLOCK_50(clk), .reset(rst), .note_on(note_on), .note_off(note_off), .sample_in(sample),
    .audio_out_allowed(allowed), .left_channel_audio_out(left0), .right_channel_audio_out(right0),
    .write_audio_out(wr0), .volume(vol0), .busy(busy0));

  note_fade_writer #(.VOL_MAX(VMAX), .HOLD_SAMPLES(HOLD), .SAMPLES_PER_STEP(SPS), .DECAY_STEP(255)) dut_f (
    .CLOCK_50(clk), .reset(rst), .note_on(note_on), .note_off(note_off), .sample_in(sample),
    .audio_out_allowed(allowed), .left_channel_audio_out(left1), .right_channel_audio_out(right1),
    .write_audio_out(wr1), .volume(vol1), .busy(busy1));

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int decay_of(input int i);
    return (i == 0) ? 1 : 255;
  endfunction

  function automatic longint floor_scale(input longint s, input int v);
    longint p, q;
    p = s * v;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_hold[i] = 0; m_dw[i] = 0; m_vol[i] = 0; m_left[i] = 0;
    end
    m_wr = 1'b0;
  endtask

  task automatic model_edge();
    bit accepted, start;
    int v;
    accepted = m_wr;
    start    = allowed && !m_wr;
    for (int i = 0; i < 2; i++) begin
      if (start) m_left[i] = floor_scale(longint'(sample), m_vol[i]);
      if (note_on) begin
        m_phase[i] = 1; m_hold[i] = 0; m_dw[i] = 0;
      end else if (m_phase[i] == 1) begin
        if (note_off) begin
          m_phase[i] = 2; m_dw[i] = 0;
        end else if (accepted) begin
          m_hold[i]++;
          if (m_hold[i] == HOLD) begin m_phase[i] = 2; m_dw[i] = 0; end
        end
      end else if (m_phase[i] == 2 && accepted) begin
        m_dw[i]++;
      end
      if (m_phase[i] == 0) v = 0;
      else if (m_phase[i] == 1) v = VMAX;
      else begin
        v = VMAX - decay_of(i) * (m_dw[i] / SPS);
        if (v <= 0) begin v = 0; m_phase[i] = 0; end
      end
      m_vol[i] = v;
    end
    m_wr = start;
  endtask

  task automatic check_all(input string w);
    check_val({w, ":wr0"}, longint'(wr0), longint'(m_wr));
    check_val({w, ":wr1"}, longint'(wr1), longint'(m_wr));
    check_val({w, ":left0"}, longint'($signed(left0)), m_left[0]);
    check_val({w, ":right0"}, longint'($signed(right0)), m_left[0]);
    check_val({w, ":vol0"}, longint'(vol0), longint'(m_vol[0]));
    check_val({w, ":busy0"}, longint'(busy0), longint'(m_phase[0] != 0));
    check_val({w, ":left1"}, longint'($signed(left1)), m_left[1]);
    check_val({w, ":vol1"}, longint'(vol1), longint'(m_vol[1]));
    check_val({w, ":busy1"}, longint'(busy1), longint'(m_phase[1] != 0));
  endtask

  task automatic step(input string w);
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    note_on  = 1'b0;
    note_off = 1'b0;
    check_all(w);
  endtask

  initial begin
    int n, c;
    bit w;
    rst = 1'b1; allowed = 1'b1; note_on = 1'b0; note_off = 1'b0; sample = 0;
    model_reset();
    #2;
    check_all("reset");
    repeat (3) step("reset_hold");

    rst = 1'b0;
    n = 0;
    repeat (6) begin step("idle_pace"); if (wr0) n++; end
    check_val("idle_strobe_count", n, 3);

    sample = 10000000; note_on = 1'b1;
    step("scale_on");
    check_val("scale_vol", longint'(vol0), 255);
    check_val("scale_busy", longint'(busy0), 1);
    repeat (2) step("scale");
    check_val("scale_pos", longint'($signed(left0)), 9960937);
    sample = -10000000;
    repeat (2) step("scale");
    check_val("scale_neg", longint'($signed(left0)), -9960938);

    note_on = 1'b1;
    step("timing_on");
    n = 0;
    for (c = 0; c < 200 && n < 16; c++) begin
      w = wr0;
      step("timing");
      if (w) begin
        n++;
        if (n == 8)  check_val("hold_end_vol", longint'(vol0), 255);
        if (n == 12) begin
          check_val("first_step_vol", longint'(vol0), 254);
          check_val("fast_idle_vol", longint'(vol1), 0);
          check_val("fast_idle_busy", longint'(busy1), 0);
        end
        if (n == 16) check_val("second_step_vol", longint'(vol0), 253);
      end
    end
    check_val("timing_writes", n, 16);

    note_on = 1'b1;
    step("bp_on");
    repeat (5) step("bp_pre");
    allowed = 1'b0;
    n = 0;
    repeat (20) begin step("bp_stall"); if (wr0) n++; end
    check_val("bp_no_strobes", n, 0);
    allowed = 1'b1;
    repeat (30) step("bp_resume");

    for (c = 0; c < 400 && vol0 != 8'd250; c++) step("to_250");
    check_val("retrig_reach_250", longint'(vol0), 250);
    note_on = 1'b1;
    step("retrig");
    check_val("retrig_vol", longint'(vol0), 255);
    check_val("retrig_busy", longint'(busy0), 1);
    repeat (6) step("retrig_hold");

    note_on = 1'b1; note_off = 1'b1;
    step("on_off");
    check_val("on_off_vol", longint'(vol0), 255);
    repeat (4) step("on_off_hold");

    note_on = 1'b1;
    step("rel_on");
    n = 0;
    for (c = 0; c < 40 && n < 3; c++) begin w = wr0; step("rel_hold"); if (w) n++; end
    note_off = 1'b1;
    step("rel_off");
    n = 0;
    for (c = 0; c < 40 && n < 4; c++) begin
      w = wr0;
      step("rel_decay");
      if (w) begin
        n++;
        if (n == 3) check_val("rel_before_step", longint'(vol0), 255);
        if (n == 4) check_val("rel_first_step", longint'(vol0), 254);
      end
    end
    check_val("rel_writes", n, 4);

    for (int k = 0; k < 1500; k++) begin
      allowed  = ($urandom % 5) != 0;
      note_on  = ($urandom % 150) == 0;
      note_off = ($urandom % 60) == 0;
      if (($urandom % 4) == 0) sample = $signed($urandom);
      else sample = $signed($urandom_range(20000000, 0)) - 10000000;
      rst = ($urandom % 700) == 0;
      step("rand");
      rst = 1'b0;
    end

    allowed = 1'b1; sample = 12345678;
    note_on = 1'b1;
    step("async_on");
    for (c = 0; c < 300 && !(vol0 <= 8'd253 && wr0); c++) step("async_seek");
    check_val("async_reach_decay", longint'(vol0 <= 8'd253 && wr0), 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("async_vol", longint'(vol0), 0);
    check_val("async_wr", longint'(wr0), 0);
    check_val("async_busy", longint'(busy0), 0);
    check_val("async_left", longint'($signed(left0)), 0);
    model_reset();
    repeat (2) step("async_hold");
    rst = 1'b0;
    repeat (6) step("async_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_note_fade_writer

// File: doc/note_fade_writer.md
Name: note_fade_writer

Overview:
- Downstream stage between the square-wave tone generator and Audio_Controller.
- Scales each incoming 32-bit tone sample by an 8-bit hold/decay volume envelope.
- Paces writes into the controller's output FIFO using audio_out_allowed and write_audio_out.
- Each note_on restarts the envelope; silence (zero samples) is written when idle so the codec never starves.

Parameters:
- VOL_W, 8, volume width in bits; scaling shift amount.
- VOL_MAX, 255, volume loaded on note_on.
- HOLD_SAMPLES, 4800, accepted samples held at VOL_MAX before decay (0.1 s at 48 kHz).
- SAMPLES_PER_STEP, 192, accepted samples per decay step.
- DECAY_STEP, 1, volume decrement per step.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- note_on  in  1  one-cycle pulse: start/retrigger note.
- note_off  in  1  one-cycle pulse: release, begin decay now.
- sample_in  in  32  signed tone sample, e.g. ±10000000.
- audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- left_channel_audio_out  out  32  scaled signed sample.
- right_channel_audio_out  out  32  identical to the left channel.
- write_audio_out  out  1  one-cycle FIFO write strobe.
- volume  out  VOL_W  current envelope level.
- busy  out  1  high in HOLD or DECAY.

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - volume=0, both channels=0, write_audio_out=0, busy=0.
  - Hold and step counters cleared.
- States: IDLE, HOLD, DECAY.
  - IDLE: volume=0. note_on -> HOLD with volume=VOL_MAX and hold_cnt=0.
  - HOLD: count accepted writes. When hold_cnt reaches HOLD_SAMPLES-1 on an accepted write, or note_off arrives -> DECAY with step_cnt=0.
  - DECAY: on the accepted write where step_cnt==SAMPLES_PER_STEP-1, volume -= DECAY_STEP (saturating at 0) and step_cnt wraps to 0. When volume reaches 0 -> IDLE.
- note_on in any state, including mid-decay, reloads VOL_MAX, clears counters and enters HOLD.
- note_on and note_off in the same cycle: note_on wins.
- note_off in IDLE or DECAY is ignored.
- Write pacing:
  - write_audio_out is registered. It rises in cycle N+1 iff audio_out_allowed=1 in cycle N and write_audio_out=0 in cycle N.
  - Maximum rate is one write per two cycles, which gives the FIFO flag a cycle to update.
  - An "accepted write" is a cycle with write_audio_out=1.
  - Writes continue in IDLE with zero data.
- Data path:
  - Channel registers update in the same edge that raises write_audio_out.
  - Value = (sample_in × zero-extended volume) arithmetically shifted right by VOL_W, using a 41-bit signed product truncated to 32 bits. Rounding is floor.
  - Data uses the volume value before any decrement on that edge.
  - Channels hold their value between writes.
- busy = (state != IDLE), registered.
- volume output is the live envelope register.
- Reset asserted mid-note: immediate return to reset values. No write strobe while reset is high.

Decomposition:
- Shared package audio_pkg:
  - State enum (IDLE, HOLD, DECAY).
  - AUDIO_W=32, VOL_W default.
  - Sample-rate constant 48000.
- One natural sub-module: sample_scaler. Purely combinational signed multiply-and-shift, reusable by other tone stages.
- Envelope FSM, counters and write pacing live in the top module.

Test Plan (sim with HOLD_SAMPLES=8, SAMPLES_PER_STEP=4, VOL_MAX=255, DECAY_STEP=1):
- Reset:
  - Stimulus: reset high, audio_out_allowed=1.
  - Response: write_audio_out=0, outputs=0. After release, strobes every second cycle with data 0.
- Scaling:
  - Stimulus: note_on, sample_in=10000000.
  - Response: first write data 9960937; sample_in=-10000000 gives -9960938. volume=255, busy=1.
- Hold/decay timing:
  - Stimulus: allowed held high.
  - Response: volume stays 255 for 8 accepted writes, then drops to 254 after 4 more writes, 253 after 8.
  - Stimulus: force volume=1 via DECAY_STEP=255 variant.
  - Response: next step gives IDLE, busy=0, data 0.
- Back-pressure:
  - Stimulus: toggle audio_out_allowed low for 20 cycles mid-HOLD.
  - Response: no strobes, counters frozen, hold resumes exactly where it stopped.
- Retrigger:
  - Stimulus: note_on during DECAY at volume 250.
  - Response: volume=255 next cycle, state HOLD, counters cleared.
  - Stimulus: note_on+note_off in the same cycle.
  - Response: HOLD.
- Release and reset mid-note:
  - Stimulus: note_off after 3 hold writes.
  - Response: DECAY entered; first decrement after 4 further writes.
  - Stimulus: assert reset asynchronously mid-DECAY.
  - Response: volume=0 and write_audio_out=0 without waiting for a clock edge.
